// File: rtl/ram2e_bank_cmd.sv
// ram2e_bank_cmd
// Snoops Apple IIe CPU cycles on the multiplexed address/data buses and
// decodes writes to the bank-select register and the command port. A small
// unlock/command sequencer adjusts the bank mask and extended-bank enable.
// A registered, masked bank address is handed to the DRAM controller.
//
// Ports:
//   C14M    - master clock; all logic on its rising edge
//   RST     - synchronous active-high reset
//   PHI0    - CPU phase, high during the CPU cycle
//   nPRAS   - Apple row-address strobe (active low)
//   nC07X   - $C070-$C07F decode (active low)
//   nWE     - CPU write (active low)
//   MA      - multiplexed address; the row carries the low address byte
//   MD      - CPU data bus
//   BA      - bank address to DRAM controller (BANKREG & MASK, or 0)
//   MASK    - current bank mask
//   EXTEN   - extended-bank enable
//   WSTB    - one-clock pulse on each committed bank-select write
//   CMDACK  - one-clock pulse when a command executes
module ram2e_bank_cmd #(
    parameter logic [7:0] RESET_MASK = 8'h1F,
    parameter logic [7:0] BANK_PORT  = 8'h73,
    parameter logic [7:0] CMD_PORT   = 8'h79
) (
    input  logic       C14M,
    input  logic       RST,
    input  logic       PHI0,
    input  logic       nPRAS,
    input  logic       nC07X,
    input  logic       nWE,
    input  logic [7:0] MA,
    input  logic [7:0] MD,
    output logic [7:0] BA,
    output logic [7:0] MASK,
    output logic       EXTEN,
    output logic       WSTB,
    output logic       CMDACK
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_U1       = 3'd1;
    localparam logic [2:0] ST_U2       = 3'd2;
    localparam logic [2:0] ST_U3       = 3'd3;
    localparam logic [2:0] ST_CMD      = 3'd4;
    localparam logic [2:0] ST_ARG_SIZE = 3'd5;
    localparam logic [2:0] ST_ARG_EN   = 3'd6;

    logic       prev_pras_r;
    logic       prev_phi0_r;
    logic       row_ok_r;
    logic       seen7x_r;
    logic       seenwr_r;
    logic [7:0] alo_r;
    logic [7:0] dlat_r;
    logic [2:0] state_r;
    logic [7:0] bankreg_r;
    logic [7:0] mask_r;
    logic       exten_r;
    logic [7:0] ba_r;
    logic       wstb_r;
    logic       cmdack_r;

    logic       row_latch_s;
    logic       ras_active_s;
    logic       commit_s;
    logic       valid_s;
    logic       bank_wr_s;
    logic       cmd_wr_s;
    logic [2:0] state_nxt_s;
    logic       bank_clr_s;
    logic       mask_ld_s;
    logic       exten_ld_s;
    logic       ack_s;

    assign row_latch_s  = PHI0 & ~nPRAS & prev_pras_r;
    assign ras_active_s = PHI0 & ~nPRAS;
    assign commit_s     = ~PHI0 & prev_phi0_r;
    // row_ok_r guards against a cycle whose RAS fall was missed: such a
    // cycle still sets the SEEN flags but must not commit with a stale ALO.
    assign valid_s      = commit_s & row_ok_r & seen7x_r & seenwr_r;
    assign bank_wr_s    = valid_s & (alo_r == BANK_PORT);
    assign cmd_wr_s     = valid_s & (alo_r == CMD_PORT);

    assign BA     = ba_r;
    assign MASK   = mask_r;
    assign EXTEN  = exten_r;
    assign WSTB   = wstb_r;
    assign CMDACK = cmdack_r;

    // Capture the CPU cycle: row byte, I/O and write flags, write data.
    always_ff @(posedge C14M) begin
        if (RST) begin
            prev_pras_r <= 1'b0;
            prev_phi0_r <= 1'b0;
            row_ok_r    <= 1'b0;
            seen7x_r    <= 1'b0;
            seenwr_r    <= 1'b0;
            alo_r       <= 8'h00;
            dlat_r      <= 8'h00;
        end else begin
            prev_pras_r <= nPRAS;
            prev_phi0_r <= PHI0;
            if (row_latch_s) begin
                alo_r    <= MA;
                row_ok_r <= 1'b1;
                seen7x_r <= ~nC07X;
                seenwr_r <= ~nWE;
            end else if (ras_active_s) begin
                seen7x_r <= seen7x_r | ~nC07X;
                seenwr_r <= seenwr_r | ~nWE;
            end else if (commit_s) begin
                // Consume the cycle so only one commit happens per PHI0 period.
                row_ok_r <= 1'b0;
                seen7x_r <= 1'b0;
                seenwr_r <= 1'b0;
            end else begin
                row_ok_r <= row_ok_r;
                seen7x_r <= seen7x_r;
                seenwr_r <= seenwr_r;
            end
            if (ras_active_s && !nWE) begin
                dlat_r <= MD;
            end else begin
                dlat_r <= dlat_r;
            end
        end
    end

    // Unlock/command sequencer next-state and action decode.
    always_comb begin
        state_nxt_s = state_r;
        bank_clr_s  = 1'b0;
        mask_ld_s   = 1'b0;
        exten_ld_s  = 1'b0;
        ack_s       = 1'b0;
        if (cmd_wr_s) begin
            case (state_r)
                ST_IDLE: state_nxt_s = (dlat_r == 8'hFF) ? ST_U1 : ST_IDLE;
                ST_U1: begin
                    if (dlat_r == 8'h00) begin
                        state_nxt_s = ST_U2;
                    end else begin
                        state_nxt_s = (dlat_r == 8'hFF) ? ST_U1 : ST_IDLE;
                    end
                end
                ST_U2: begin
                    if (dlat_r == 8'h55) begin
                        state_nxt_s = ST_U3;
                    end else begin
                        state_nxt_s = (dlat_r == 8'hFF) ? ST_U1 : ST_IDLE;
                    end
                end
                ST_U3: begin
                    if (dlat_r == 8'hAA) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = (dlat_r == 8'hFF) ? ST_U1 : ST_IDLE;
                    end
                end
                ST_CMD: begin
                    case (dlat_r)
                        8'h52: begin
                            bank_clr_s  = 1'b1;
                            ack_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                        8'h53:   state_nxt_s = ST_ARG_SIZE;
                        8'h45:   state_nxt_s = ST_ARG_EN;
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end
                ST_ARG_SIZE: begin
                    mask_ld_s   = 1'b1;
                    ack_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_ARG_EN: begin
                    exten_ld_s  = 1'b1;
                    ack_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Configuration registers, sequencer state and strobes, updated at commit.
    always_ff @(posedge C14M) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            bankreg_r <= 8'h00;
            mask_r    <= RESET_MASK;
            exten_r   <= 1'b1;
            wstb_r    <= 1'b0;
            cmdack_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wstb_r   <= bank_wr_s;
            cmdack_r <= ack_s;
            if (bank_wr_s) begin
                bankreg_r <= dlat_r;
            end else if (bank_clr_s) begin
                bankreg_r <= 8'h00;
            end else begin
                bankreg_r <= bankreg_r;
            end
            mask_r  <= mask_ld_s ? dlat_r : mask_r;
            exten_r <= exten_ld_s ? dlat_r[0] : exten_r;
        end
    end

    // Registered bank address, one clock behind any configuration change.
    always_ff @(posedge C14M) begin
        if (RST) begin
            ba_r <= 8'h00;
        end else begin
            ba_r <= exten_r ? (bankreg_r & mask_r) : 8'h00;
        end
    end

endmodule

// File: tb/tb_ram2e_bank_cmd.sv
module tb_ram2e_bank_cmd;

    logic       C14M = 1'b0;
    logic       RST = 1'b1;
    logic       PHI0 = 1'b0;
    logic       nPRAS = 1'b1;
    logic       nC07X = 1'b1;
    logic       nWE = 1'b1;
    logic [7:0] MA = 8'h00;
    logic [7:0] MD = 8'h00;
    logic [7:0] BA;
    logic [7:0] MASK;
    logic       EXTEN;
    logic       WSTB;
    logic       CMDACK;

    int n_checks = 0;
    int n_fail = 0;

    // Expected pulse events: 2'b10 = WSTB, 2'b01 = CMDACK.
    logic [1:0] exp_q[$];

    ram2e_bank_cmd dut (
        .C14M(C14M), .RST(RST), .PHI0(PHI0), .nPRAS(nPRAS), .nC07X(nC07X),
        .nWE(nWE), .MA(MA), .MD(MD), .BA(BA), .MASK(MASK), .EXTEN(EXTEN),
        .WSTB(WSTB), .CMDACK(CMDACK)
    );

    always #5 C14M = ~C14M;

    // Monitor: every observed strobe must match the next expected event.
    always @(negedge C14M) begin
        logic [1:0] got;
        logic [1:0] want;
        got = {WSTB, CMDACK};
        if (!RST && got != 2'b00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got WSTB/CMDACK=%b, required none at %0t", got, $time);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    n_fail++;
                    $display("FAIL pulse_kind: got WSTB/CMDACK=%b, required %b at %0t", got, want, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] ba, input logic [7:0] mask,
                               input logic exten);
        @(negedge C14M);
        check8({name, "_BA"}, BA, ba);
        check8({name, "_MASK"}, MASK, mask);
        check8({name, "_EXTEN"}, {7'd0, EXTEN}, {7'd0, exten});
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pulse_missing: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One CPU cycle. early_ras drops nPRAS before PHI0 rises; rst_mid pulses
    // RST while the cycle is in progress.
    task automatic cpu_cycle(input logic [7:0] addr, input logic [7:0] data, input logic wr,
                             input logic io, input logic early_ras, input logic rst_mid);
        @(negedge C14M);
        PHI0 = 1'b0; nPRAS = early_ras ? 1'b0 : 1'b1; nWE = 1'b1; nC07X = 1'b1; MA = 8'h00;
        repeat (2) @(negedge C14M);
        PHI0 = 1'b1;
        @(negedge C14M);
        nPRAS = 1'b0; MA = addr; nC07X = ~io;
        @(negedge C14M);
        MA = ~addr; nWE = ~wr; MD = data;
        repeat (3) @(negedge C14M);
        if (rst_mid) begin
            RST = 1'b1;
            repeat (2) @(negedge C14M);
            RST = 1'b0;
            @(negedge C14M);
        end
        PHI0 = 1'b0; nPRAS = 1'b1; nWE = 1'b1; nC07X = 1'b1;
        repeat (4) @(negedge C14M);
    endtask

    task automatic wr_bank(input logic [7:0] d);
        exp_q.push_back(2'b10);
        cpu_cycle(8'h73, d, 1'b1, 1'b1, 1'b0, 1'b0);
        check_drained("bank_wr");
    endtask

    task automatic wr_cmd(input logic [7:0] d, input logic ack);
        if (ack) exp_q.push_back(2'b01);
        cpu_cycle(8'h79, d, 1'b1, 1'b1, 1'b0, 1'b0);
        if (ack) check_drained("cmd_wr");
    endtask

    task automatic unlock();
        wr_cmd(8'hFF, 1'b0);
        wr_cmd(8'h00, 1'b0);
        wr_cmd(8'h55, 1'b0);
        wr_cmd(8'hAA, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge C14M);
        RST = 1'b1;
        repeat (2) @(negedge C14M);
        RST = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge C14M);
        RST = 1'b0;
        check_state("reset", 8'h00, 8'h1F, 1'b1);
        check8("reset_WSTB", {7'd0, WSTB}, 8'h00);
        check8("reset_CMDACK", {7'd0, CMDACK}, 8'h00);

        // Bank write, masked by reset mask.
        wr_bank(8'h2A);
        check_state("bank_2A", 8'h0A, 8'h1F, 1'b1);
        // Read and non-I/O write have no effect.
        cpu_cycle(8'h73, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check_state("read_73", 8'h0A, 8'h1F, 1'b1);
        cpu_cycle(8'h73, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("no_io_73", 8'h0A, 8'h1F, 1'b1);

        // Size command.
        unlock();
        wr_cmd(8'h53, 1'b0);
        wr_cmd(8'h7F, 1'b1);
        wr_bank(8'h2A);
        check_state("size_7F", 8'h2A, 8'h7F, 1'b1);

        // Restarted unlock then enable-off command.
        wr_cmd(8'hFF, 1'b0);
        wr_cmd(8'h00, 1'b0);
        wr_cmd(8'hFF, 1'b0);
        wr_cmd(8'h00, 1'b0);
        wr_cmd(8'h55, 1'b0);
        wr_cmd(8'hAA, 1'b0);
        wr_cmd(8'h45, 1'b0);
        wr_cmd(8'h00, 1'b1);
        check_state("exten_off", 8'h00, 8'h7F, 1'b0);
        unlock();
        wr_cmd(8'h45, 1'b0);
        wr_cmd(8'h01, 1'b1);
        check_state("exten_on", 8'h2A, 8'h7F, 1'b1);

        // Clear-bank command.
        wr_bank(8'h0F);
        check_state("bank_0F", 8'h0F, 8'h7F, 1'b1);
        unlock();
        wr_cmd(8'h52, 1'b1);
        check_state("clear_52", 8'h00, 8'h7F, 1'b1);

        // Unknown command returns to IDLE without ACK.
        unlock();
        wr_cmd(8'h99, 1'b0);
        wr_cmd(8'hAA, 1'b0);
        wr_cmd(8'h53, 1'b0);
        wr_cmd(8'h3F, 1'b0);
        check_drained("unknown_cmd");
        check_state("unknown_cmd", 8'h00, 8'h7F, 1'b1);

        // RAS already low on the first PHI0 edge: cycle ignored.
        cpu_cycle(8'h73, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
        check_state("early_ras", 8'h00, 8'h7F, 1'b1);
        wr_bank(8'h44);
        check_state("bank_44", 8'h44, 8'h7F, 1'b1);

        // Reset in the middle of a bank write: no commit afterwards.
        cpu_cycle(8'h73, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
        check_state("rst_mid", 8'h00, 8'h1F, 1'b1);

        // Reset while in U3, then AA/53/7F is ignored.
        wr_cmd(8'hFF, 1'b0);
        wr_cmd(8'h00, 1'b0);
        wr_cmd(8'h55, 1'b0);
        do_reset();
        wr_cmd(8'hAA, 1'b0);
        wr_cmd(8'h53, 1'b0);
        wr_cmd(8'h7F, 1'b0);
        check_drained("rst_u3");
        check_state("rst_u3", 8'h00, 8'h1F, 1'b1);

        // Sequencer still functional after reset.
        unlock();
        wr_cmd(8'h53, 1'b0);
        wr_cmd(8'h3F, 1'b1);
        wr_bank(8'hFF);
        check_state("size_3F", 8'h3F, 8'h3F, 1'b1);

        repeat (4) @(negedge C14M);
        check_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
